// File: rtl/sym_lut_seq.sv
// sym_lut_seq: fetches one 8-column symbol (real row, imaginary row) from an external
// LUT and streams it out under valid/ready. Define SYM_LUT_SEQ_CONJ_EN to honour conj.
module sym_lut_seq #(
  parameter int WIDTH = 16,
  parameter int COLL  = 8,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sym,
  input  logic             conj,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] lut_row,
  output logic [2:0]       lut_col,
  input  logic [WIDTH-1:0] lut_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [2:0]       out_col,
  output logic             out_last
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_RE = 3'd1,
    FETCH_IM = 3'd2,
    CAP      = 3'd3,
    PRESENT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] LAST_COL = 3'(COLL - 32'sd1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         sym_r;
  logic               conj_r;
  logic [2:0]         col_r;
  logic [WIDTH-1:0]   out_re_r;
  logic [WIDTH-1:0]   out_im_r;
  logic [2:0]         out_col_r;
  logic [WIDTH-1:0]   im_cap_s;
  logic [ROW_W-1:0]   row_base_s;

  // Symbol s occupies rows 3+2s (real) and 4+2s (imaginary)
  assign row_base_s = ROW_W'({sym_r, 1'b0});

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = FETCH_RE;
        else       state_nxt_s = IDLE;
      end
      FETCH_RE: state_nxt_s = FETCH_IM;
      FETCH_IM: state_nxt_s = CAP;
      CAP:      state_nxt_s = PRESENT;
      PRESENT: begin
        if (out_ready) begin
          if (col_r == LAST_COL) state_nxt_s = DONE;
          else                   state_nxt_s = FETCH_RE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      DONE:     state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // LUT address drive; read data lands one cycle after the address
  always_comb begin
    lut_row = {ROW_W{1'b0}};
    lut_col = 3'd0;
    case (state_r)
      FETCH_RE: begin
        lut_row = row_base_s + ROW_W'(3'd3);
        lut_col = col_r;
      end
      FETCH_IM: begin
        lut_row = row_base_s + ROW_W'(3'd4);
        lut_col = col_r;
      end
      default: begin
        lut_row = {ROW_W{1'b0}};
        lut_col = 3'd0;
      end
    endcase
  end

`ifdef SYM_LUT_SEQ_CONJ_EN
  // Imaginary capture value, negated (wrapping) for a conjugate readout
  always_comb begin
    im_cap_s = lut_data;
    if (conj_r) im_cap_s = {WIDTH{1'b0}} - lut_data;
    else        im_cap_s = lut_data;
  end
`else
  logic unused_conj_s;
  assign unused_conj_s = conj_r;

  // Imaginary capture value passes straight through
  always_comb begin
    im_cap_s = lut_data;
  end
`endif

  // Request latch, column counter and sample capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_r     <= 4'd0;
      conj_r    <= 1'b0;
      col_r     <= 3'd0;
      out_re_r  <= {WIDTH{1'b0}};
      out_im_r  <= {WIDTH{1'b0}};
      out_col_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sym_r  <= sym;
            conj_r <= conj;
            col_r  <= 3'd0;
          end
        end
        FETCH_IM: out_re_r <= lut_data;
        CAP: begin
          out_im_r  <= im_cap_s;
          out_col_r <= col_r;
        end
        PRESENT: begin
          if (out_ready && (col_r != LAST_COL)) col_r <= col_r + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign out_valid = (state_r == PRESENT);
  assign out_last  = (state_r == PRESENT) && (out_col_r == LAST_COL);
  assign out_re    = out_re_r;
  assign out_im    = out_im_r;
  assign out_col   = out_col_r;

endmodule

// File: tb/tb_sym_lut_seq.sv
// tb_sym_lut_seq: directed bench for sym_lut_seq with a registered-read LUT model.
// Expected out_im for the conjugate case follows SYM_LUT_SEQ_CONJ_EN.
module tb_sym_lut_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sym;
  logic        conj;
  logic        busy;
  logic        done;
  logic [5:0]  lut_row;
  logic [2:0]  lut_col;
  logic [15:0] lut_data = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [2:0]  out_col;
  logic        out_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] lut_mem [0:511];
  logic [15:0] exp_re [0:7];
  logic [15:0] exp_im [0:7];

  sym_lut_seq #(.WIDTH(16), .COLL(8), .ROW_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sym(sym), .conj(conj),
    .busy(busy), .done(done), .lut_row(lut_row), .lut_col(lut_col),
    .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: data valid one cycle after the address
  always @(posedge clk) lut_data <= lut_mem[{lut_row, lut_col}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One readout; stall_k/inj_k/abort_k < 0 disables that feature
  task automatic run_sym(input logic [3:0] s, input logic c, input int stall_k,
                         input int stall_n, input int inj_k, input int abort_k,
                         input int exp_done);
    int k, ph, stall_left, t0;
    bit fin;
    k = 0; ph = 0; stall_left = stall_n; fin = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; sym = s; conj = c; out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      ph++;
      if (k == 8) begin
        check($sformatf("s%0d done", s), 32'(done), 32'd1);
        check($sformatf("s%0d done_time", s), 32'(cyc - t0), 32'(exp_done));
        @(negedge clk);
        check($sformatf("s%0d done_pulse_end", s), 32'(done), 32'd0);
        check($sformatf("s%0d idle_busy", s), 32'(busy), 32'd0);
        fin = 1'b1;
      end else begin
        check($sformatf("s%0d busy k%0d", s, k), 32'(busy), 32'd1);
        check($sformatf("s%0d valid k%0d ph%0d", s, k, ph), 32'(out_valid), 32'(ph >= 4));
        check($sformatf("s%0d last k%0d ph%0d", s, k, ph), 32'(out_last), 32'((ph >= 4) && (k == 7)));
        check($sformatf("s%0d done_low k%0d", s, k), 32'(done), 32'd0);
        if (ph == 1) begin
          check($sformatf("s%0d row_re k%0d", s, k), 32'(lut_row), 32'(3 + 2 * int'(s)));
          check($sformatf("s%0d col_re k%0d", s, k), 32'(lut_col), 32'(k));
        end else if (ph == 2) begin
          check($sformatf("s%0d row_im k%0d", s, k), 32'(lut_row), 32'(4 + 2 * int'(s)));
          check($sformatf("s%0d col_im k%0d", s, k), 32'(lut_col), 32'(k));
          if (k == inj_k) begin
            start = 1'b1;
            sym   = 4'd9;
          end
        end else if (ph == 3) begin
          check($sformatf("s%0d row_cap k%0d", s, k), 32'(lut_row), 32'd0);
        end else begin
          check($sformatf("s%0d re k%0d", s, k), 32'(out_re), 32'(exp_re[k]));
          check($sformatf("s%0d im k%0d", s, k), 32'(out_im), 32'(exp_im[k]));
          check($sformatf("s%0d out_col k%0d", s, k), 32'(out_col), 32'(k));
          if (k == abort_k) begin
            rst = 1'b0; out_ready = 1'b0; fin = 1'b1;
          end else if (k == stall_k && stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
          end else begin
            out_ready = 1'b1; k++; ph = 0;
          end
        end
      end
    end
    if (!fin) check($sformatf("s%0d timeout", s), 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) lut_mem[i] = 16'h0000;
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 8; c++) begin
        lut_mem[(3 + 2 * s) * 8 + c] = (s == 9) ? 16'h0007 : 16'h0001;
        lut_mem[(4 + 2 * s) * 8 + c] = 16'h0000;
      end
    end
    lut_mem[3 * 8 + 2] = 16'hFFFF; lut_mem[3 * 8 + 6] = 16'hFFFF;
    lut_mem[5 * 8 + 2] = 16'hFFFF; lut_mem[5 * 8 + 5] = 16'h0000; lut_mem[5 * 8 + 6] = 16'h0000;
    lut_mem[6 * 8 + 5] = 16'h0001; lut_mem[6 * 8 + 6] = 16'h0001;
    lut_mem[7 * 8 + 2] = 16'hFFFF; lut_mem[7 * 8 + 5] = 16'hFFFF;
    lut_mem[10 * 8 + 5] = 16'hFFFF; lut_mem[10 * 8 + 6] = 16'hFFFF;
    lut_mem[34 * 8 + 4] = 16'hFFFF;

    rst = 1'b0; start = 1'b0; sym = 4'd0; conj = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst last", 32'(out_last), 32'd0);
    check("rst re", 32'(out_re), 32'd0);
    check("rst im", 32'(out_im), 32'd0);
    check("rst col", 32'(out_col), 32'd0);
    check("rst row", 32'(lut_row), 32'd0);

    // sym 0, start released with reset, a stray sym 9 start mid-readout
    exp_re = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_sym(4'd0, 1'b0, -1, 0, 2, -1, 33);

    exp_re = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001};
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    run_sym(4'd1, 1'b0, -1, 0, -1, -1, 33);

`ifdef SYM_LUT_SEQ_CONJ_EN
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
`else
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
`endif
    exp_re = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    run_sym(4'd3, 1'b1, -1, 0, -1, -1, 33);

    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    run_sym(4'd15, 1'b0, 4, 5, -1, -1, 38);

    // Reset during PRESENT at column 3 with out_ready low
    exp_re = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_sym(4'd0, 1'b0, -1, 0, -1, 3, 0);
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort last", 32'(out_last), 32'd0);
    check("abort re", 32'(out_re), 32'd0);
    check("abort im", 32'(out_im), 32'd0);
    check("abort col", 32'(out_col), 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("abort no_done", 32'(done), 32'd0);
    check("abort idle", 32'(busy), 32'd0);

    exp_re = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
    run_sym(4'd2, 1'b0, -1, 0, -1, -1, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_lut_seq.md
SYM_LUT_SEQ -- requirements
Module: sym_lut_seq

Interface
REQ-001 Parameter: WIDTH, 16, LUT word width in bits.
REQ-002 Parameter: COLL, 8, columns per LUT row.
REQ-003 Parameter: ROW_W, 6, width of the LUT row address.
REQ-004 clk  input  1  single clock; all logic updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request a readout of one symbol.
REQ-007 sym  input  4  symbol index 0..15, selecting S1..S16.
REQ-008 conj  input  1  conjugate request; sampled together with start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when a readout completes.
REQ-011 lut_row  output  ROW_W  row address to the symbol LUT.
REQ-012 lut_col  output  3  column address to the symbol LUT.
REQ-013 lut_data  input  WIDTH  LUT read data; valid one cycle after the address.
REQ-014 out_valid  output  1  output sample valid.
REQ-015 out_ready  input  1  downstream accepts the sample.
REQ-016 out_re / out_im  output  WIDTH each  real and imaginary parts of the sample, two's complement.
REQ-017 out_col  output  3  column index of the current sample.
REQ-018 out_last  output  1  high with the column-7 sample.

Function
REQ-019 FSM states: IDLE, FETCH_RE, FETCH_IM, CAP, PRESENT, DONE.
REQ-020 Start acceptance: IDLE with start=1 latches sym and conj, clears the column counter, and goes to FETCH_RE.
- start is ignored in every other state.
REQ-021 Address drive, combinational from state:
- FETCH_RE: lut_row = 3+2*sym, lut_col = column counter.
- FETCH_IM: lut_row = 4+2*sym, lut_col = column counter.
- All other states: lut_row = 0, lut_col = 0.
REQ-022 The row calculation is 6-bit unsigned; the maximum row is 34, and rows 0-2 and 35-36 are never addressed.
REQ-023 Capture and state sequence:
- FETCH_RE goes to FETCH_IM.
- FETCH_IM registers lut_data into out_re and goes to CAP.
- CAP registers lut_data into out_im and goes to PRESENT.
REQ-024 PRESENT asserts out_valid.
- out_re, out_im, out_col and out_last stay stable while out_ready=0.
REQ-025 Handshake (out_valid & out_ready) in PRESENT:
- Column below 7: increment the column and go to FETCH_RE.
- Column 7: go to DONE.
REQ-026 DONE pulses done for exactly one cycle, then returns to IDLE.
REQ-027 Latency:
- The start-accept cycle is T.
- First out_valid appears at T+4.
- With out_ready held high, one sample every 4 cycles.
- Last handshake at T+32, done at T+33.
REQ-028 out_last equals (out_col==7) while out_valid=1, and is 0 otherwise.
REQ-029 out_valid is low in every state except PRESENT.

Reset
REQ-030 rst=0 on a clock edge forces IDLE in every state, including mid-readout and while out_valid=1 with out_ready=0.
REQ-031 Reset values:
- busy, done, out_valid, out_last = 0.
- out_re, out_im, out_col = 0.
- Column counter, latched sym, latched conj = 0.
- Partial readouts are discarded, and no done pulse is produced.
REQ-032 The first start is accepted in the first cycle that rst=1 is sampled.

Configuration
REQ-033 Macro SYM_LUT_SEQ_CONJ_EN.
- Defined: when the latched conj=1, CAP stores 0 - lut_data (WIDTH-bit two's complement, wrapping) into out_im; out_re is unaffected.
- Undefined: the conj port exists but is ignored, and out_im always equals lut_data.

Verification
REQ-034 sym=0, out_ready=1:
- out_re = 1,1,-1,1,1,1,-1,1 (0x0001/0xFFFF).
- out_im all 0.
- out_col = 0..7, out_last on column 7, done at T+33.
REQ-035 sym=1, out_ready=1:
- out_re = 1,1,-1,1,1,0,0,1.
- out_im = 0,0,0,0,0,1,1,0.
- lut_row toggles between 5 and 6.
REQ-036 sym=3 with conj=1 and macro defined:
- Columns 5 and 6 give out_im = 0x0001.
- Without the macro, out_im = 0xFFFF.
REQ-037 sym=15 with out_ready low for 5 cycles at column 4:
- out_im = 0xFFFF is held stable for the full stall.
- Sequence resumes with column 5; total done time extends by 5 cycles.
REQ-038 rst=0 asserted at column 3 during PRESENT:
- Next cycle: IDLE, all outputs 0, no done pulse.
- A new start with sym=2 then yields out_re = 1,1,-1,1,1,-1,1,1.
REQ-039 start pulsed with sym=9 while busy on sym=0:
- Ignored; the sym=0 data completes unchanged.
- The next start after done is accepted.
